// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through cache sequencer (tag/valid arrays, data-array strobes, memory handshake)
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module cache_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CACHE_LINES = 4,
  parameter int INDEX_BITS  = 2,
  parameter int OFFSET_BITS = 4,
  parameter int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] arr_addr,
  output logic                  read_data,
  output logic                  refill,
  output logic                  update,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
`endif
  output logic                  arr_clr
);
  localparam logic [2:0] IDLE = 3'd0, COMPARE = 3'd1, RESP = 3'd2, MEM_RD = 3'd3, REFILL = 3'd4, MEM_WR = 3'd5;
  logic [2:0] state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic req_we, first, hit_q, hit;
  logic [1:0] beat;
  logic [CACHE_LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [CACHE_LINES];
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] req_tag;
  always_comb begin
    idx = req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    req_tag = req_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    hit = valid[idx] && tags[idx] == req_tag;
    cpu_ready = state == RESP;
    cpu_hit = cpu_ready && hit_q;
    mem_req = state == MEM_RD || state == MEM_WR;
    mem_we = state == MEM_WR;
    mem_addr = state == MEM_RD ? {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} :
               state == MEM_WR ? req_addr : '0;
    read_data = state == COMPARE && !req_we && hit;
    update = state == COMPARE && req_we && hit;
    refill = state == REFILL;
    arr_addr = refill ? {req_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'({beat, 2'b00})} :
               (read_data || update) ? req_addr : '0;
    // gated by rst so a flush held through reset cannot leak a clear strobe
    arr_clr = rst && state == IDLE && flush;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req_addr <= '0;
      req_we <= 1'b0;
      first <= 1'b0;
      hit_q <= 1'b0;
      beat <= '0;
      valid <= '0;
      for (int i = 0; i < CACHE_LINES; i++) tags[i] <= '0;
    end else begin
      case (state)
        IDLE:
          if (flush) valid <= '0;
          else if (cpu_req) begin
            req_addr <= cpu_addr;
            req_we <= cpu_we;
            first <= 1'b1;
            state <= COMPARE;
          end
        COMPARE: begin
          if (first) hit_q <= hit;
          first <= 1'b0;
          state <= req_we ? MEM_WR : hit ? RESP : MEM_RD;
        end
        MEM_RD:
          if (mem_ack) begin
            beat <= '0;
            state <= REFILL;
          end
        REFILL: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            valid[idx] <= 1'b1;
            tags[idx] <= req_tag;
            state <= COMPARE;
          end
        end
        MEM_WR: if (mem_ack) state <= RESP;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (state == COMPARE && first) begin
      if (hit && ~&hit_cnt) hit_cnt <= hit_cnt + 32'd1;
      if (!hit && ~&miss_cnt) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
